bpsk_packet_decoder: RTL and testbench

- Next-generation BPSK symbol decoder. It sits between the CORDIC/matched-filter output and the packet FIFO.
- On a preamble trigger it integrates signed baseband samples over a configurable window around each symbol centre and slices each window to one bit.
- It assembles PACKET_LENGTH bits MSB-first and emits each packet on an AXI-Stream master with full tready backpressure.
- New relative to the previous decoder: parametrised samples-per-symbol, first-sample offset and window; integrate-and-dump decisions; abort; output handshake; drop/packet counters.

---
 rtl/bpsk_packet_decoder_if.sv | 38 +++
 rtl/bpsk_packet_decoder.sv | 114 +++++++++++
 tb/tb_bpsk_packet_decoder.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bpsk_packet_decoder_if.sv
// bpsk_packet_decoder_if: sample stream into the decoder and packet stream out of it.
// BPSK_DEC_CONFIDENCE_EN adds the m00 tuser confidence field.
interface bpsk_packet_decoder_if #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int PACKET_LENGTH = 128
`ifdef BPSK_DEC_CONFIDENCE_EN
    ,
    parameter int INTEG_WINDOW = 8
`endif
);
    logic [SAMPLE_WIDTH-1:0] s00_axis_tdata;
    logic s00_axis_tvalid;
    logic s00_axis_tready;
    logic [PACKET_LENGTH-1:0] m00_axis_tdata;
    logic m00_axis_tvalid;
    logic m00_axis_tready;
    logic m00_axis_tlast;
`ifdef BPSK_DEC_CONFIDENCE_EN
    logic [SAMPLE_WIDTH+$clog2(INTEG_WINDOW):0] m00_axis_tuser;
    modport master (
        input s00_axis_tdata, s00_axis_tvalid, m00_axis_tready,
        output s00_axis_tready, m00_axis_tdata, m00_axis_tvalid, m00_axis_tlast, m00_axis_tuser
    );
    modport slave (
        output s00_axis_tdata, s00_axis_tvalid, m00_axis_tready,
        input s00_axis_tready, m00_axis_tdata, m00_axis_tvalid, m00_axis_tlast, m00_axis_tuser
    );
`else
    modport master (
        input s00_axis_tdata, s00_axis_tvalid, m00_axis_tready,
        output s00_axis_tready, m00_axis_tdata, m00_axis_tvalid, m00_axis_tlast
    );
    modport slave (
        output s00_axis_tdata, s00_axis_tvalid, m00_axis_tready,
        input s00_axis_tready, m00_axis_tdata, m00_axis_tvalid, m00_axis_tlast
    );
`endif
endinterface

// File: rtl/bpsk_packet_decoder.sv
// bpsk_packet_decoder: integrate-and-dump BPSK slicer assembling MSB-first packets onto AXI-Stream.
// BPSK_DEC_CONFIDENCE_EN reports the packet's minimum |window sum| on m00_axis_tuser.
module bpsk_packet_decoder #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SAMPLES_PER_SYMBOL = 32,
    parameter int PACKET_LENGTH = 128,
    parameter int FIRST_OFFSET = 16,
    parameter int INTEG_WINDOW = 8,
    parameter int CNT_WIDTH = 16
) (
    input logic s00_axis_aclk,
    input logic s00_axis_aresetn,
    bpsk_packet_decoder_if.master axis,
    input logic [1:0] trigger,
    input logic abort,
    output logic busy,
    output logic [CNT_WIDTH-1:0] pkt_count,
    output logic [CNT_WIDTH-1:0] drop_count
);
    localparam int AW = SAMPLE_WIDTH + $clog2(INTEG_WINDOW) + 1;
    localparam int PMAX = FIRST_OFFSET > SAMPLES_PER_SYMBOL - 1 ? FIRST_OFFSET : SAMPLES_PER_SYMBOL - 1;
    localparam int PW = $clog2(PMAX + 1);
    localparam int BW = $clog2(PACKET_LENGTH);
    localparam logic [PW-1:0] POS_FIRST = PW'(FIRST_OFFSET);
    localparam logic [PW-1:0] POS_RELOAD = PW'(SAMPLES_PER_SYMBOL - 1);
    localparam logic [PW-1:0] POS_WIN = PW'(INTEG_WINDOW - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(PACKET_LENGTH - 1);

    typedef enum logic [1:0] {IDLE, RECORD, OUTPUT} state_t;
    state_t state, state_next;
    logic polarity;
    logic [PW-1:0] pos;
    logic [BW-1:0] bit_cnt;
    logic signed [AW-1:0] acc, sample, sum;
    logic [PACKET_LENGTH-1:0] shreg, shreg_next;
    logic start, step, decide, last;

    // pos counts valid samples remaining until the next decision; the window is its last INTEG_WINDOW values
    assign sample = {{(AW-SAMPLE_WIDTH){axis.s00_axis_tdata[SAMPLE_WIDTH-1]}}, axis.s00_axis_tdata};
    assign sum = (pos == POS_WIN ? '0 : acc) + sample;
    assign start = state == IDLE && trigger[0] && !abort;
    assign step = state == RECORD && !abort && axis.s00_axis_tvalid;
    assign decide = step && pos == '0;
    assign last = decide && bit_cnt == LAST_BIT;
    assign shreg_next = {shreg[PACKET_LENGTH-2:0], ~sum[AW-1] ^ polarity};
    assign axis.s00_axis_tready = 1'b1;

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) state <= IDLE;
        else state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: state_next = start ? RECORD : IDLE;
            RECORD: state_next = abort ? IDLE : last ? OUTPUT : RECORD;
            OUTPUT: state_next = axis.m00_axis_tready ? IDLE : OUTPUT;
            default: state_next = IDLE;
        endcase
        busy = state != IDLE;
        axis.m00_axis_tvalid = state == OUTPUT;
        axis.m00_axis_tlast = state == OUTPUT;
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            polarity <= 1'b0;
            pos <= '0;
            bit_cnt <= '0;
            acc <= '0;
            shreg <= '0;
            axis.m00_axis_tdata <= '0;
            pkt_count <= '0;
            drop_count <= '0;
        end else begin
            if (start) begin
                polarity <= trigger[1];
                pos <= POS_FIRST;
                bit_cnt <= '0;
                acc <= '0;
                shreg <= '0;
            end else if (step) begin
                if (pos <= POS_WIN) acc <= sum;
                pos <= decide ? POS_RELOAD : pos - 1'b1;
                if (decide) begin
                    bit_cnt <= bit_cnt + 1'b1;
                    shreg <= shreg_next;
                end
                if (last) axis.m00_axis_tdata <= shreg_next;
            end
            if (state == OUTPUT && axis.m00_axis_tready) pkt_count <= pkt_count + 1'b1;
            if (trigger[0] && state != IDLE && drop_count != '1) drop_count <= drop_count + 1'b1;
        end
    end

`ifdef BPSK_DEC_CONFIDENCE_EN
    logic [AW-1:0] conf_min, mag, conf_next;
    assign mag = sum[AW-1] ? AW'(-sum) : AW'(sum);
    assign conf_next = mag < conf_min ? mag : conf_min;

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            conf_min <= '0;
            axis.m00_axis_tuser <= '0;
        end else if (start) begin
            conf_min <= '1;
        end else if (decide) begin
            conf_min <= conf_next;
            if (last) axis.m00_axis_tuser <= conf_next;
        end
    end
`endif
endmodule

// File: tb/tb_bpsk_packet_decoder.sv
// tb_bpsk_packet_decoder: randomized scenarios checked against a window-sum reference model.
// Define BPSK_DEC_CONFIDENCE_EN to also check m00_axis_tuser.
module tb_bpsk_packet_decoder;
    localparam int SW = 16, SPS = 8, PL = 8, FO = 4, W = 4, CW = 16;
    localparam int NS = FO + (PL - 1) * SPS + 1;
    localparam int UW = SW + $clog2(W) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] trigger = 2'b00;
    logic abort = 1'b0;
    logic busy;
    logic [CW-1:0] pkt_count, drop_count;
    int nv = 0, nerr = 0, exp_pkt = 0, exp_drop = 0;
    logic signed [SW-1:0] smp [64];

    bpsk_packet_decoder_if #(
        .SAMPLE_WIDTH(SW),
        .PACKET_LENGTH(PL)
`ifdef BPSK_DEC_CONFIDENCE_EN
        ,
        .INTEG_WINDOW(W)
`endif
    ) bus ();

    bpsk_packet_decoder #(
        .SAMPLE_WIDTH(SW),
        .SAMPLES_PER_SYMBOL(SPS),
        .PACKET_LENGTH(PL),
        .FIRST_OFFSET(FO),
        .INTEG_WINDOW(W),
        .CNT_WIDTH(CW)
    ) dut (
        .s00_axis_aclk(clk),
        .s00_axis_aresetn(rst_n),
        .axis(bus),
        .trigger(trigger),
        .abort(abort),
        .busy(busy),
        .pkt_count(pkt_count),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Reference: bit n sums the W valid samples ending at index FO+n*SPS.
    function automatic void model(input bit pol, output logic [PL-1:0] d, output int cmin);
        cmin = 1 << 30;
        for (int n = 0; n < PL; n++) begin
            int s = 0;
            for (int j = 0; j < W; j++) s += int'(smp[FO + n * SPS - j]);
            d[PL-1-n] = (s >= 0) ^ pol;
            if ((s < 0 ? -s : s) < cmin) cmin = s < 0 ? -s : s;
        end
    endfunction

    task automatic build_pattern(input logic [PL-1:0] pat, input int amp, input int noise);
        for (int k = 0; k < 64; k++) begin
            int nz = noise > 0 ? int'($urandom_range(2 * noise)) - noise : 0;
            smp[k] = SW'((pat[PL-1-k/SPS] ? amp : -amp) + nz);
        end
    endtask

    task automatic build_window(input int a0, input int a1, input int a2, input int a3);
        for (int k = 0; k < 64; k++) begin
            int p = k % SPS;
            smp[k] = SW'(p == 1 ? a0 : p == 2 ? a1 : p == 3 ? a2 : p == 4 ? a3 :
                         int'($urandom_range(40000)) - 20000);
        end
    endtask

    task automatic trig(input bit pol);
        @(negedge clk);
        trigger = {pol, 1'b1};
        bus.s00_axis_tvalid = 1'b0;
    endtask

    task automatic feed(input int n, input int gap_pct);
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            @(negedge clk);
            trigger = 2'b00;
            while ($urandom_range(99) < gap_pct && guard < 50) begin
                bus.s00_axis_tvalid = 1'b0;
                bus.s00_axis_tdata = SW'($urandom);
                guard++;
                @(negedge clk);
            end
            bus.s00_axis_tvalid = 1'b1;
            bus.s00_axis_tdata = smp[i];
            if (i == NS - 1) begin
                nv++;
                if (bus.m00_axis_tvalid !== 1'b0) begin
                    nerr++;
                    $display("FAIL early_tvalid: got %b want 0", bus.m00_axis_tvalid);
                end
            end
        end
    endtask

    task automatic expect_pkt(input logic [PL-1:0] exp_d, input int exp_conf, input int hold,
                              input int trig_at, input int abort_at);
        exp_pkt++;
        bus.m00_axis_tready = (hold == 0);
        for (int c = 0; c < (hold > 0 ? hold : 1); c++) begin
            @(negedge clk);
            bus.s00_axis_tvalid = 1'b0;
            trigger = (c == trig_at) ? 2'b01 : 2'b00;
            abort = (c == abort_at);
            if (c == trig_at) exp_drop++;
            nv++;
            if (bus.m00_axis_tvalid !== 1'b1 || bus.m00_axis_tlast !== 1'b1 || busy !== 1'b1 ||
                bus.m00_axis_tdata !== exp_d) begin
                nerr++;
                $display("FAIL pkt_hold[%0d]: got data=%h valid=%b last=%b busy=%b want data=%h valid=1 last=1 busy=1",
                         c, bus.m00_axis_tdata, bus.m00_axis_tvalid, bus.m00_axis_tlast, busy, exp_d);
            end
`ifdef BPSK_DEC_CONFIDENCE_EN
            nv++;
            if (bus.m00_axis_tuser !== UW'(exp_conf)) begin
                nerr++;
                $display("FAIL tuser: got %0d want %0d", bus.m00_axis_tuser, exp_conf);
            end
`endif
            if (c >= hold - 1) bus.m00_axis_tready = 1'b1;
        end
        @(negedge clk);
        trigger = 2'b00;
        abort = 1'b0;
        bus.m00_axis_tready = 1'b0;
        nv++;
        if (bus.m00_axis_tvalid !== 1'b0 || busy !== 1'b0 || pkt_count !== CW'(exp_pkt)) begin
            nerr++;
            $display("FAIL pkt_done: got valid=%b busy=%b pkt_count=%0d want valid=0 busy=0 pkt_count=%0d",
                     bus.m00_axis_tvalid, busy, pkt_count, exp_pkt);
        end
        nv++;
        if (drop_count !== CW'(exp_drop)) begin
            nerr++;
            $display("FAIL drop_count: got %0d want %0d", drop_count, exp_drop);
        end
    endtask

    task automatic run_pkt(input bit pol, input logic [PL-1:0] exp_d, input int gap, input int hold,
                           input int trig_at, input int abort_at);
        logic [PL-1:0] md;
        int mc;
        model(pol, md, mc);
        trig(pol);
        feed(NS, gap);
        expect_pkt(exp_d, mc, hold, trig_at, abort_at);
    endtask

    task automatic check_idle(input string name);
        nv++;
        if (busy !== 1'b0 || bus.m00_axis_tvalid !== 1'b0 || pkt_count !== CW'(exp_pkt)) begin
            nerr++;
            $display("FAIL %s: got busy=%b valid=%b pkt_count=%0d want busy=0 valid=0 pkt_count=%0d",
                     name, busy, bus.m00_axis_tvalid, pkt_count, exp_pkt);
        end
    endtask

    task automatic test_reset;
        bus.s00_axis_tvalid = 1'b0;
        bus.s00_axis_tdata = '0;
        bus.m00_axis_tready = 1'b0;
        repeat (3) @(negedge clk);
        nv++;
        if (bus.m00_axis_tvalid !== 1'b0 || bus.m00_axis_tlast !== 1'b0 || bus.m00_axis_tdata !== '0 ||
            busy !== 1'b0 || pkt_count !== '0 || drop_count !== '0 || bus.s00_axis_tready !== 1'b1) begin
            nerr++;
            $display("FAIL reset: got valid=%b last=%b data=%h busy=%b pkt=%0d drop=%0d ready=%b want all 0, ready=1",
                     bus.m00_axis_tvalid, bus.m00_axis_tlast, bus.m00_axis_tdata, busy, pkt_count, drop_count,
                     bus.s00_axis_tready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("reset_release");
    endtask

    task automatic test_pattern;
        build_pattern(8'hB2, 1000, 0);
        run_pkt(1'b0, 8'hB2, 0, 0, -1, -1);
        run_pkt(1'b1, 8'h4D, 0, 0, -1, -1);
    endtask

    task automatic test_zero_sum;
        build_window(3000, -1000, -1000, -1000);
        run_pkt(1'b0, 8'hFF, 0, 0, -1, -1);
        build_window(-3000, 1000, 1000, 999);
        run_pkt(1'b0, 8'h00, 0, 0, -1, -1);
    endtask

    task automatic test_gaps_backpressure;
        build_pattern(8'hB2, 1000, 0);
        run_pkt(1'b0, 8'hB2, 50, 20, 7, -1);
        repeat (5) begin
            @(negedge clk);
            check_idle("no_second_capture");
        end
    endtask

    task automatic test_abort;
        build_pattern(8'hA7, 1000, 200);
        trig(1'b0);
        feed(FO + 2 * SPS + 1, 0);
        @(negedge clk);
        bus.s00_axis_tvalid = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle("abort_record");
        trigger = 2'b01;
        abort = 1'b1;
        @(negedge clk);
        trigger = 2'b00;
        abort = 1'b0;
        check_idle("abort_beats_trigger");
        build_pattern(8'h5A, 1000, 300);
        run_pkt(1'b0, 8'h5A, 0, 4, -1, 1);
    endtask

    task automatic test_reset_mid;
        build_pattern(8'h3C, 1500, 500);
        trig(1'b1);
        feed(30, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_pkt = 0;
        exp_drop = 0;
        nv++;
        if (bus.m00_axis_tvalid !== 1'b0 || bus.m00_axis_tdata !== '0 || busy !== 1'b0 ||
            pkt_count !== '0 || drop_count !== '0) begin
            nerr++;
            $display("FAIL reset_mid: got valid=%b data=%h busy=%b pkt=%0d drop=%0d want all 0",
                     bus.m00_axis_tvalid, bus.m00_axis_tdata, busy, pkt_count, drop_count);
        end
        bus.s00_axis_tvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        build_pattern(8'hB2, 1000, 0);
        run_pkt(1'b0, 8'hB2, 0, 0, -1, -1);
    endtask

    task automatic test_random;
        for (int t = 0; t < 8; t++) begin
            logic [PL-1:0] md;
            int mc;
            bit pol = 1'($urandom);
            int amp = int'($urandom_range(3000, 500));
            build_pattern(PL'($urandom), amp, int'($urandom_range(2 * amp)));
            model(pol, md, mc);
            run_pkt(pol, md, int'($urandom_range(60)), int'($urandom_range(5)), -1, -1);
        end
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_zero_sum();
        test_gaps_backpressure();
        test_abort();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nv, nerr);
        $finish;
    end
endmodule
